// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin arbiter that runs fill/drain countdown jobs on a shared seconds counter.
module counter_scheduler #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       reqFill,
  input  logic       reqDrain,
  input  logic [9:0] fillSeconds,
  input  logic [9:0] drainSeconds,
  input  logic       abort,
  input  logic       counterDone,
  output logic       start,
  output logic [9:0] counterSeconds,
  output logic       grantFill,
  output logic       grantDrain,
  output logic       doneFill,
  output logic       doneDrain,
  output logic       busy,
  output logic       fault
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, COMPLETE} state_t;
  localparam logic FILL = 1'b0;
  localparam logic DRAIN = 1'b1;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, fault_q, fault_d, winner, timeout;
  logic [9:0] secs_q, secs_d, win_secs;
  logic [15:0] wd_q, wd_d;
  logic start_q, start_d, gf_q, gf_d, gd_q, gd_d, df_q, df_d, dd_q, dd_d, busy_q, busy_d;
  // last_q resets to DRAIN so the first contended grant goes to fill
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      owner_q <= FILL;
      last_q  <= DRAIN;
      secs_q  <= '0;
      wd_q    <= '0;
      fault_q <= 1'b0;
      start_q <= 1'b0;
      gf_q    <= 1'b0;
      gd_q    <= 1'b0;
      df_q    <= 1'b0;
      dd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      secs_q  <= secs_d;
      wd_q    <= wd_d;
      fault_q <= fault_d;
      start_q <= start_d;
      gf_q    <= gf_d;
      gd_q    <= gd_d;
      df_q    <= df_d;
      dd_q    <= dd_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    winner   = (reqFill & reqDrain) ? ~last_q : reqDrain;
    win_secs = winner ? drainSeconds : fillSeconds;
    timeout  = (wd_q + 16'd1) == TIMEOUT_CYCLES;
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    secs_d   = secs_q;
    fault_d  = fault_q;
    wd_d     = (state_q == RUN) ? wd_q + 16'd1 : '0;
    case (state_q)
      IDLE: if (reqFill | reqDrain) begin
        state_d = (win_secs == '0) ? COMPLETE : LOAD;
        owner_d = winner;
        secs_d  = win_secs;
      end
      LOAD: state_d = abort ? IDLE : RUN;
      RUN: if (abort) state_d = IDLE;
        else if (counterDone) state_d = COMPLETE;
        else if (timeout) begin
          state_d = IDLE;
          fault_d = 1'b1;
          last_d  = owner_q;
        end
      default: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
    endcase
  end
  // outputs are decoded from the next state so every port comes straight off a flop
  always_comb begin
    busy_d  = state_d != IDLE;
    start_d = state_d == LOAD;
    gf_d    = busy_d & (owner_d == FILL);
    gd_d    = busy_d & (owner_d == DRAIN);
    df_d    = (state_d == COMPLETE) & (owner_d == FILL);
    dd_d    = (state_d == COMPLETE) & (owner_d == DRAIN);
  end
  assign start          = start_q;
  assign counterSeconds = secs_q;
  assign grantFill      = gf_q;
  assign grantDrain     = gd_q;
  assign doneFill       = df_q;
  assign doneDrain      = dd_q;
  assign busy           = busy_q;
  assign fault          = fault_q;
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: cycle-by-cycle vector table for counter_scheduler with a 5-cycle watchdog.
module tb_counter_scheduler;
  typedef struct {
    logic       rst, rf, rd;
    logic [9:0] fs, ds;
    logic       ab, cd;
    logic [6:0] exp;
    logic [9:0] secs;
    logic       chk;
  } vec_t;
  localparam logic [6:0] S = 7'h40, GF = 7'h20, GD = 7'h10, DF = 7'h08, DD = 7'h04, B = 7'h02, F = 7'h01;
  logic Clock = 1'b0, Reset = 1'b0, reqFill = 1'b0, reqDrain = 1'b0, abort = 1'b0, counterDone = 1'b0;
  logic [9:0] fillSeconds = '0, drainSeconds = '0, counterSeconds;
  logic start, grantFill, grantDrain, doneFill, doneDrain, busy, fault;
  logic [6:0] got;
  int n_checks = 0, n_fails = 0, row = 0;
  vec_t tbl[$];

  counter_scheduler #(.TIMEOUT_CYCLES(16'd5)) dut (
    .Clock(Clock), .Reset(Reset), .reqFill(reqFill), .reqDrain(reqDrain),
    .fillSeconds(fillSeconds), .drainSeconds(drainSeconds), .abort(abort),
    .counterDone(counterDone), .start(start), .counterSeconds(counterSeconds),
    .grantFill(grantFill), .grantDrain(grantDrain), .doneFill(doneFill),
    .doneDrain(doneDrain), .busy(busy), .fault(fault)
  );

  always #5 Clock = ~Clock;

  function automatic vec_t mk(logic rst, logic rf, logic rd, logic [9:0] fs, logic [9:0] ds,
                              logic ab, logic cd, logic [6:0] exp, logic [9:0] secs, logic chk);
    vec_t v;
    v.rst = rst; v.rf = rf; v.rd = rd; v.fs = fs; v.ds = ds;
    v.ab = ab; v.cd = cd; v.exp = exp; v.secs = secs; v.chk = chk;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge Clock);
    Reset = v.rst; reqFill = v.rf; reqDrain = v.rd; fillSeconds = v.fs;
    drainSeconds = v.ds; abort = v.ab; counterDone = v.cd;
    @(posedge Clock);
    #1;
    row++;
    got = {start, grantFill, grantDrain, doneFill, doneDrain, busy, fault};
    n_checks++;
    if (got !== v.exp) begin
      n_fails++;
      $display("FAIL row %0d flags {start,gF,gD,dF,dD,busy,fault}: got %b expected %b", row, got, v.exp);
    end
    if (v.chk) begin
      n_checks++;
      if (counterSeconds !== v.secs) begin
        n_fails++;
        $display("FAIL row %0d counterSeconds: got %0d expected %0d", row, counterSeconds, v.secs);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    // reset, then a single fill job of 7 seconds with request dropped after grant
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,         0, 1));
    tbl.push_back(mk(0,1,0, 7,0, 0,0, S|GF|B,    7, 1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, GF|B,      7, 1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, GF|B,      7, 1));
    tbl.push_back(mk(0,0,0, 0,0, 0,1, GF|DF|B,   7, 1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,         0, 0));
    // zero-length drain job skips LOAD/RUN
    tbl.push_back(mk(0,0,1, 0,0, 0,0, GD|DD|B,   0, 1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,         0, 0));
    // both held: fill, drain, fill, drain with one idle cycle between
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) begin
        tbl.push_back(mk(0,1,1, 4,5, 0,0, S|GF|B,  4, 1));
        tbl.push_back(mk(0,1,1, 4,5, 0,0, GF|B,    4, 1));
        tbl.push_back(mk(0,1,1, 4,5, 0,0, GF|B,    4, 1));
        tbl.push_back(mk(0,1,1, 4,5, 0,1, GF|DF|B, 4, 1));
      end else begin
        tbl.push_back(mk(0,1,1, 4,5, 0,0, S|GD|B,  5, 1));
        tbl.push_back(mk(0,1,1, 4,5, 0,0, GD|B,    5, 1));
        tbl.push_back(mk(0,1,1, 4,5, 0,0, GD|B,    5, 1));
        tbl.push_back(mk(0,1,1, 4,5, 0,1, GD|DD|B, 5, 1));
      end
      tbl.push_back(mk(0,j < 3,j < 3, 4,5, 0,0, 0, 0, 0));
    end
    // drain in RUN, abort and counterDone together; pointer stays on drain
    tbl.push_back(mk(0,0,1, 0,9, 0,0, S|GD|B,    9, 1));
    tbl.push_back(mk(0,0,0, 0,9, 0,0, GD|B,      9, 1));
    tbl.push_back(mk(0,0,0, 0,9, 1,1, 0,         0, 0));
    tbl.push_back(mk(0,1,1, 2,3, 0,0, S|GF|B,    2, 1));
    // abort in LOAD, then abort in IDLE ignored
    tbl.push_back(mk(0,0,0, 2,3, 1,0, 0,         0, 0));
    tbl.push_back(mk(0,1,0, 3,0, 1,0, S|GF|B,    3, 1));
    // five RUN cycles without counterDone -> fault
    for (int j = 0; j < 5; j++) tbl.push_back(mk(0,0,0, 3,0, 0,0, GF|B, 3, 1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, F,         0, 0));
    tbl.push_back(mk(0,0,0, 0,0, 0,1, F,         0, 0));
    // pointer now fill, so contended grant goes to drain; fault stays set
    tbl.push_back(mk(0,1,1, 1,2, 0,0, S|GD|B|F,  2, 1));
    tbl.push_back(mk(0,0,0, 1,2, 0,0, GD|B|F,    2, 1));
    tbl.push_back(mk(0,0,0, 1,2, 0,1, GD|DD|B|F, 2, 1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, F,         0, 0));
    // reset mid-job clears everything, counterDone in IDLE ignored, fill first again
    tbl.push_back(mk(0,1,0, 6,0, 0,0, S|GF|B|F,  6, 1));
    tbl.push_back(mk(0,0,0, 6,0, 0,0, GF|B|F,    6, 1));
    tbl.push_back(mk(1,1,0, 6,0, 0,1, 0,         0, 1));
    tbl.push_back(mk(0,0,0, 0,0, 0,1, 0,         0, 1));
    tbl.push_back(mk(0,1,1, 8,9, 0,0, S|GF|B,    8, 1));
    tbl.push_back(mk(0,0,0, 8,9, 1,0, 0,         0, 0));
    foreach (tbl[i]) apply(tbl[i]);
    // counterDone in LOAD ignored, abort in COMPLETE ignored so pointer moves to fill
    apply(mk(0,1,0, 2,6, 0,0, S|GF|B,  2, 1));
    apply(mk(0,0,0, 2,6, 0,1, GF|B,    2, 1));
    apply(mk(0,0,0, 2,6, 0,1, GF|DF|B, 2, 1));
    apply(mk(0,0,0, 2,6, 1,0, 0,       0, 0));
    apply(mk(0,1,1, 2,6, 0,0, S|GD|B,  6, 1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
